// File: rtl/sn74ls49_pkg.sv
// Glyph constants, FSM state type and pattern-to-code decode for the SN74LS49 glyph set.
// Latency: none. Everything here is constants and combinational helpers.
// Backpressure: not applicable.
package sn74ls49_pkg;

   // Segment patterns are ordered {a,b,c,d,e,f,g}, with 1 meaning the segment is lit
   localparam logic [6:0] SEG_0 = 7'h7E;
   localparam logic [6:0] SEG_1 = 7'h30;
   localparam logic [6:0] SEG_2 = 7'h6D;
   localparam logic [6:0] SEG_3 = 7'h79;
   localparam logic [6:0] SEG_4 = 7'h33;
   localparam logic [6:0] SEG_5 = 7'h5B;
   localparam logic [6:0] SEG_6 = 7'h1F;
   localparam logic [6:0] SEG_7 = 7'h70;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h73;
   localparam logic [6:0] SEG_A = 7'h0D;
   localparam logic [6:0] SEG_B = 7'h19;
   localparam logic [6:0] SEG_C = 7'h23;
   localparam logic [6:0] SEG_D = 7'h4B;
   localparam logic [6:0] SEG_E = 7'h0F;
   localparam logic [6:0] SEG_F = 7'h00;

   typedef enum logic {TRACK = 1'b0, PEND = 1'b1} state_t;

   // Decoded word as it sits in the output slot
   typedef struct packed {
      logic       illegal;
      logic       blank;
      logic [3:0] code;
   } word_t;

   // Returns {illegal, code}. Patterns outside the glyph table decode to code 0 with illegal set.
   function automatic logic [4:0] seg_to_code(input logic [6:0] pat);
      logic [4:0] r;
      case (pat)
         SEG_0:   r = 5'h00;
         SEG_1:   r = 5'h01;
         SEG_2:   r = 5'h02;
         SEG_3:   r = 5'h03;
         SEG_4:   r = 5'h04;
         SEG_5:   r = 5'h05;
         SEG_6:   r = 5'h06;
         SEG_7:   r = 5'h07;
         SEG_8:   r = 5'h08;
         SEG_9:   r = 5'h09;
         SEG_A:   r = 5'h0A;
         SEG_B:   r = 5'h0B;
         SEG_C:   r = 5'h0C;
         SEG_D:   r = 5'h0D;
         SEG_E:   r = 5'h0E;
         SEG_F:   r = 5'h0F;
         default: r = 5'h10;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg_sync.sv
// Two-flop synchronizer for a bundle of independent asynchronous lines.
// Latency: 2 clk cycles.
// Backpressure: none. It samples on every cycle.
module seg_sync #(
   parameter int unsigned W = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // Two-stage capture. Both stages reset to all-off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sn74ls49_reader.sv
// Recovers 4-bit codes from 7-segment lines, filtering glitches and suppressing repeats.
// Latency: STABLE_CYCLES+3 cycles from a clean step on the segment lines to out_valid.
// Backpressure: one-deep output slot. A settled event waits in PEND and flags overrun while the slot is busy.
module sn74ls49_reader #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       seg_a,
   input  logic       seg_b,
   input  logic       seg_c,
   input  logic       seg_d,
   input  logic       seg_e,
   input  logic       seg_f,
   input  logic       seg_g,
   input  logic       out_ready,
   input  logic       clr_overrun,
   output logic       out_valid,
   output logic [3:0] out_code,
   output logic       out_blank,
   output logic       out_illegal,
   output logic       overrun
);
   import sn74ls49_pkg::*;

   localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES);
   localparam logic [7:0] CNT_SETTLE = 8'(STABLE_CYCLES - 1);

   logic [6:0] pat;
   logic [6:0] cand;
   logic [7:0] cnt;
   logic [6:0] last_pat;
   logic       last_valid;
   logic       pat_chg;
   logic       settled;
   logic       slot_free;
   logic       load;
   logic       set_ovr;
   state_t     state, state_nxt;
   word_t      word_nxt;
   logic [4:0] dec;

   seg_sync #(.W(7)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   ({seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}),
      .q   (pat)
   );

   assign pat_chg   = (pat != cand);
   assign settled   = !pat_chg && (cnt == CNT_SETTLE);
   assign slot_free = !out_valid || out_ready;

   // Stability counter: restart on any change and saturate once the pattern has been steady long enough
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand <= '0;
         cnt  <= '0;
      end else if (pat_chg) begin
         cand <= pat;
         cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt  <= cnt + 8'd1;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= TRACK;
      else     state <= state_nxt;
   end

   // Next state. A pattern change while pending discards the event.
   always_comb begin
      state_nxt = state;
      case (state)
         TRACK: if (settled && (!last_valid || cand != last_pat)) state_nxt = PEND;
         PEND:  if (pat_chg || slot_free)                          state_nxt = TRACK;
         default:                                                  state_nxt = TRACK;
      endcase
   end

   // FSM outputs: load the slot when it frees up, and flag overrun while it stays busy
   always_comb begin
      load    = 1'b0;
      set_ovr = 1'b0;
      if (state == PEND && !pat_chg) begin
         load    = slot_free;
         set_ovr = !slot_free;
      end
   end

   assign dec      = seg_to_code(cand);
   assign word_nxt = '{illegal: dec[4], blank: (cand == SEG_F), code: dec[3:0]};

   // Output slot: new data on load, otherwise drop valid once the word has been accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_code    <= '0;
         out_blank   <= 1'b0;
         out_illegal <= 1'b0;
      end else if (load) begin
         out_valid   <= 1'b1;
         out_code    <= word_nxt.code;
         out_blank   <= word_nxt.blank;
         out_illegal <= word_nxt.illegal;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

   // Remember the last delivered pattern so that holding it steady produces no repeat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_pat   <= '0;
         last_valid <= 1'b0;
      end else if (load) begin
         last_pat   <= cand;
         last_valid <= 1'b1;
      end
   end

   // Sticky overrun flag. A set in the same cycle as a clear takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              overrun <= 1'b0;
      else if (set_ovr)     overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
   end

endmodule

// File: tb/tb_sn74ls49_reader.sv
// Directed bench for sn74ls49_reader: a glyph table sweep plus hand-written handshake and reset sequences.
// Latency: checks that a word appears STABLE_CYCLES+3 edges after a step (edge 7 at default).
// Backpressure: exercises a stalled consumer, overrun, and the accept-and-reload cycle.
module tb_sn74ls49_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] seg = 7'h7E;
   logic       out_ready = 1'b1;
   logic       clr_overrun = 1'b0;
   logic       out_valid;
   logic [3:0] out_code;
   logic       out_blank;
   logic       out_illegal;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [6:0] pat;
      logic [3:0] code;
      logic       ill;
      logic       blank;
   } vec_t;

   vec_t tbl [18];

   sn74ls49_reader #(.STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_a       (seg[6]),
      .seg_b       (seg[5]),
      .seg_c       (seg[4]),
      .seg_d       (seg[3]),
      .seg_e       (seg[2]),
      .seg_f       (seg[1]),
      .seg_g       (seg[0]),
      .out_ready   (out_ready),
      .clr_overrun (clr_overrun),
      .out_valid   (out_valid),
      .out_code    (out_code),
      .out_blank   (out_blank),
      .out_illegal (out_illegal),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count accepted words over n edges. pos is the 0-based index of the edge after which the first word appeared.
   task automatic window(input int n, output int words, output int pos,
                         output int code, output int ill, output int blank);
      words = 0; pos = -1; code = -1; ill = -1; blank = -1;
      for (int i = 0; i < n; i++) begin
         tick();
         if (out_valid && out_ready) begin
            if (pos < 0) begin
               pos = i; code = out_code; ill = out_illegal; blank = out_blank;
            end
            words++;
         end
      end
   endtask

   initial begin
      int w, p, c, il, bl, n;

      tbl[0]  = '{7'h7E, 4'h0, 1'b0, 1'b0};
      tbl[1]  = '{7'h30, 4'h1, 1'b0, 1'b0};
      tbl[2]  = '{7'h6D, 4'h2, 1'b0, 1'b0};
      tbl[3]  = '{7'h79, 4'h3, 1'b0, 1'b0};
      tbl[4]  = '{7'h33, 4'h4, 1'b0, 1'b0};
      tbl[5]  = '{7'h5B, 4'h5, 1'b0, 1'b0};
      tbl[6]  = '{7'h1F, 4'h6, 1'b0, 1'b0};
      tbl[7]  = '{7'h70, 4'h7, 1'b0, 1'b0};
      tbl[8]  = '{7'h7F, 4'h8, 1'b0, 1'b0};
      tbl[9]  = '{7'h73, 4'h9, 1'b0, 1'b0};
      tbl[10] = '{7'h0D, 4'hA, 1'b0, 1'b0};
      tbl[11] = '{7'h19, 4'hB, 1'b0, 1'b0};
      tbl[12] = '{7'h23, 4'hC, 1'b0, 1'b0};
      tbl[13] = '{7'h4B, 4'hD, 1'b0, 1'b0};
      tbl[14] = '{7'h0F, 4'hE, 1'b0, 1'b0};
      tbl[15] = '{7'h00, 4'hF, 1'b0, 1'b1};
      tbl[16] = '{7'h01, 4'h0, 1'b1, 1'b0};
      tbl[17] = '{7'h00, 4'hF, 1'b0, 1'b1};

      // Reset state
      repeat (3) tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_code", out_code, 0);
      chk("rst_blank", out_blank, 0);
      chk("rst_illegal", out_illegal, 0);
      chk("rst_overrun", overrun, 0);

      // First word after reset, then no repeats while the pattern is held
      rst = 1'b0;
      window(9, w, p, c, il, bl);
      chk("t1_words", w, 1);
      chk("t1_edge", p, 7);
      chk("t1_code", c, 0);
      chk("t1_illegal", il, 0);
      chk("t1_blank", bl, 0);
      window(100, w, p, c, il, bl);
      chk("t1_no_repeat", w, 0);

      // A short glitch to 30 and back to 7E produces nothing
      seg = 7'h30;
      tick(); tick();
      seg = 7'h7E;
      window(20, w, p, c, il, bl);
      chk("t2_words", w, 0);
      chk("t2_overrun", overrun, 0);

      // Stalled consumer: word 9 is held, 7F settles behind it and raises overrun
      out_ready = 1'b0;
      seg = 7'h73;
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      chk("t3_latency", n, 8);
      chk("t3_code9", out_code, 9);
      repeat (3) tick();
      chk("t3_held_valid", out_valid, 1);
      chk("t3_held_code", out_code, 9);
      seg = 7'h7F;
      repeat (10) tick();
      chk("t3_overrun_set", overrun, 1);
      chk("t3_still_valid", out_valid, 1);
      chk("t3_still_code9", out_code, 9);
      out_ready = 1'b1;
      tick();
      chk("t3_reload_valid", out_valid, 1);
      chk("t3_reload_code8", out_code, 8);
      tick();
      chk("t3_drained", out_valid, 0);
      chk("t3_overrun_sticky", overrun, 1);
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      chk("t3_overrun_clr", overrun, 0);

      // Sweep all glyphs in order, then an illegal pattern, then blank again
      for (int i = 0; i < 18; i++) begin
         seg = tbl[i].pat;
         window(8, w, p, c, il, bl);
         chk($sformatf("sweep%0d_words", i), w, 1);
         chk($sformatf("sweep%0d_edge", i), p, 7);
         chk($sformatf("sweep%0d_code", i), c, int'(tbl[i].code));
         chk($sformatf("sweep%0d_illegal", i), il, int'(tbl[i].ill));
         chk($sformatf("sweep%0d_blank", i), bl, int'(tbl[i].blank));
      end

      // Reset mid-count clears the outputs at once, and the held pattern is reported again
      seg = 7'h33;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      chk("t5a_valid", out_valid, 0);
      chk("t5a_code", out_code, 0);
      chk("t5a_blank", out_blank, 0);
      tick();
      rst = 1'b0;
      window(8, w, p, c, il, bl);
      chk("t5a_words", w, 1);
      chk("t5a_edge", p, 7);
      chk("t5a_code4", c, 4);

      // Reset while a word is waiting for the consumer
      out_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      chk("t5b_latency", n, 8);
      repeat (2) tick();
      chk("t5b_pending", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("t5b_valid", out_valid, 0);
      chk("t5b_code", out_code, 0);
      chk("t5b_overrun", overrun, 0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      window(8, w, p, c, il, bl);
      chk("t5b_words", w, 1);
      chk("t5b_edge", p, 7);
      chk("t5b_code4", c, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
